// File: rtl/rom_copy_ctrl_pkg.sv
// Shared types and default geometry for the ROM-to-RAM copy path.
package rom_copy_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } copy_state_t;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 4;
  localparam int DEF_LAST_ADDR = 15;
  localparam int DEF_RD_LAT    = 1;

endpackage

// File: rtl/rom_copy_ctrl_valid_delay.sv
// Fixed-depth 1-bit shift line that tracks which read cycles return data.
module valid_delay #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] line;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      line <= '0;
    end else begin
      line[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        line[i] <= line[i-1];
      end
    end
  end

  assign q = line[STAGES-1];

endmodule

// File: rtl/rom_copy_ctrl.sv
// Copy sequencer: fetch/write every address, then read back and checksum.
module rom_copy_ctrl
  import rom_copy_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LAST_ADDR = DEF_LAST_ADDR,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [ADDR_W-1:0]        addr,
  output logic                     we,
  input  logic [DATA_W-1:0]        q_in,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_valid,
  output logic [ADDR_W+DATA_W-1:0] sum
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  copy_state_t   state;
  logic [CW-1:0] drain_cnt;
  logic          rd_issue;

  assign rd_issue = (state == S_READ);

  valid_delay #(.STAGES(RD_LAT)) u_valid_delay (
    .clk   (clk),
    .clr_n (rst_n),
    .d     (rd_issue),
    .q     (rd_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      we        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      drain_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (rd_valid) begin
        sum <= sum + {{ADDR_W{1'b0}}, q_in};
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            addr  <= '0;
            we    <= 1'b0;
            busy  <= 1'b1;
            sum   <= '0;
          end
        end
        S_FETCH: begin
          state <= S_WRITE;
          we    <= 1'b1;
        end
        S_WRITE: begin
          we <= 1'b0;
          if (addr == LAST) begin
            state <= S_READ;
            addr  <= '0;
          end else begin
            state <= S_FETCH;
            addr  <= addr + 1'b1;
          end
        end
        S_READ: begin
          // addr parks on LAST through the drain window
          if (addr == LAST) begin
            state     <= S_DRAIN;
            drain_cnt <= CW'(RD_LAT - 1);
          end else begin
            addr <= addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            addr  <= '0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          addr  <= '0;
          we    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
